// File: rtl/count_interval_arbiter_pkg.sv
// Shared types and constants for the count-interval arbiter.
//   state_t     : sequencer states IDLE/CLEAR/COUNT/DONE
//   REQ0, REQ1  : requester indices into req/gnt/done
//   onehot      : requester index -> one-hot grant vector
package count_interval_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/count_interval_arbiter_sync_event_counter.sv
// Synchronous clear / increment event counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : increment by one
//   q        : counter value
module sync_event_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/count_interval_arbiter.sv
// Round-robin sequencer sharing one event counter between two requesters.
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : level requests, held until done or withdrawn
//   len0, len1 : interval lengths, sampled at grant
//   tick       : count-event strobe
//   gnt[1:0]   : registered one-hot grant
//   busy       : sequencer not idle
//   done[1:0]  : one-cycle completion pulse to the winner
//   cnt        : current counter value
module count_interval_arbiter
  import count_interval_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             tick,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] cnt
);

  state_t           state;
  logic             win;
  logic             last_served;
  logic [WIDTH-1:0] len_r;

  logic             win_req_c;
  logic             clr_c;
  logic             en_c;
  logic             term_c;
  logic             idle_win_c;
  logic [WIDTH-1:0] idle_len_c;

  // Abort is taken when the current winner withdraws; counter holds then.
  assign win_req_c = req[win];
  assign clr_c     = (state == CLEAR) && win_req_c;
  assign en_c      = (state == COUNT) && tick && win_req_c;
  // len_r-1 is only meaningful for a non-zero interval.
  assign term_c    = (len_r != '0) && (cnt == len_r - WIDTH'(1));

  // Round-robin pick: on contention favour the requester not served last.
  always_comb begin
    idle_win_c = 1'b0;
    if (req[REQ0] && req[REQ1]) idle_win_c = ~last_served;
    else                        idle_win_c = req[REQ1];
    idle_len_c = idle_win_c ? len1 : len0;
  end

  sync_event_counter #(.WIDTH(WIDTH)) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr_c),
    .en  (en_c),
    .q   (cnt)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      done        <= 2'b00;
      busy        <= 1'b0;
      len_r       <= '0;
      win         <= 1'b0;
      last_served <= 1'b1;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= idle_win_c;
            len_r <= idle_len_c;
            gnt   <= onehot(idle_win_c);
            busy  <= 1'b1;
            state <= (idle_len_c == '0) ? DONE : CLEAR;
          end else begin
            gnt  <= 2'b00;
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          if (!win_req_c) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            busy        <= 1'b0;
            last_served <= win;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!win_req_c) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            busy        <= 1'b0;
            last_served <= win;
          end else if (tick && term_c) begin
            state <= DONE;
            done  <= gnt;
          end
        end
        DONE: begin
          // A zero-length interval arrives here without its pulse yet;
          // issue it now so done still trails the grant by one cycle.
          if (done == 2'b00) begin
            done <= gnt;
          end else begin
            state       <= IDLE;
            gnt         <= 2'b00;
            busy        <= 1'b0;
            last_served <= win;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_interval_arbiter.sv
module tb_count_interval_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       tick;
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic [3:0] cnt;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       pre_rst;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       tick;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  count_interval_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .tick (tick),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic p, input logic [1:0] r, input logic [3:0] a,
                              input logic [3:0] b, input logic t, input logic [1:0] g,
                              input logic [1:0] d, input logic bz, input logic [3:0] c,
                              input string nm);
    vec_t v;
    v.pre_rst = p; v.req = r; v.len0 = a; v.len1 = b; v.tick = t;
    v.gnt = g; v.done = d; v.busy = bz; v.cnt = c; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [1:0] g, input logic [1:0] d,
                       input logic bz, input logic [3:0] c);
    n_cmp++;
    if (gnt !== g || done !== d || busy !== bz || cnt !== c) begin
      n_err++;
      $display("FAIL %s: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
               nm, gnt, done, busy, cnt, g, d, bz, c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; tick = 1'b0; len0 = 4'd0; len1 = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; req = 2'b00; tick = 1'b0; len0 = 4'd0; len1 = 4'd0;

    // Single request len0=3; len0 changes after grant must be ignored.
    add(1, 2'b01, 4'd3, 4'd0, 1, 2'b01, 2'b00, 1, 4'd0, "single_e0");
    add(0, 2'b01, 4'd7, 4'd0, 1, 2'b01, 2'b00, 1, 4'd0, "single_e1");
    add(0, 2'b01, 4'd7, 4'd0, 1, 2'b01, 2'b00, 1, 4'd1, "single_e2");
    add(0, 2'b01, 4'd7, 4'd0, 1, 2'b01, 2'b00, 1, 4'd2, "single_e3");
    add(0, 2'b01, 4'd7, 4'd0, 1, 2'b01, 2'b01, 1, 4'd3, "single_e4");
    add(0, 2'b00, 4'd7, 4'd0, 1, 2'b00, 2'b00, 0, 4'd3, "single_e5");
    add(0, 2'b00, 4'd7, 4'd0, 1, 2'b00, 2'b00, 0, 4'd3, "single_e6");
    // Contention from reset: 0 first, then 1, then 0 again.
    add(1, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b00, 1, 4'd0, "cont_e0");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b00, 1, 4'd0, "cont_e1");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b00, 1, 4'd1, "cont_e2");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b01, 1, 4'd2, "cont_e3");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b00, 2'b00, 0, 4'd2, "cont_e4");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b00, 1, 4'd2, "cont_e5");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b00, 1, 4'd0, "cont_e6");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b00, 1, 4'd1, "cont_e7");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b00, 1, 4'd2, "cont_e8");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b00, 1, 4'd3, "cont_e9");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b10, 2'b10, 1, 4'd4, "cont_e10");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b00, 2'b00, 0, 4'd4, "cont_e11");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b00, 1, 4'd4, "cont_e12");
    add(0, 2'b11, 4'd2, 4'd4, 1, 2'b01, 2'b00, 1, 4'd0, "cont_e13");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) begin
        do_reset();
        check("reset", 2'b00, 2'b00, 1'b0, 4'd0);
      end
      req = vecs[i].req; len0 = vecs[i].len0; len1 = vecs[i].len1; tick = vecs[i].tick;
      step();
      check(vecs[i].name, vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt);
    end

    // Sparse ticks: requester 1, len1=5, tick every third cycle.
    do_reset();
    req = 2'b10; len1 = 4'd5; tick = 1'b0;
    step(); check("sparse_grant", 2'b10, 2'b00, 1'b1, 4'd0);
    tick = 1'b1;
    step(); check("sparse_clear", 2'b10, 2'b00, 1'b1, 4'd0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick = (k % 3 == 2);
      step();
      if (tick) n++;
      check($sformatf("sparse_%0d", k), 2'b10, (tick && n == 5) ? 2'b10 : 2'b00, 1'b1, 4'(n));
      if (n == 5) break;
    end
    tick = 1'b0; req = 2'b00;
    step(); check("sparse_end", 2'b00, 2'b00, 1'b0, 4'd5);

    // Maximum length: counts to 15 without wrapping.
    do_reset();
    req = 2'b01; len0 = 4'd15; tick = 1'b1;
    step(); check("max_grant", 2'b01, 2'b00, 1'b1, 4'd0);
    step(); check("max_clear", 2'b01, 2'b00, 1'b1, 4'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("max_%0d", k), 2'b01, (k == 15) ? 2'b01 : 2'b00, 1'b1, 4'(k));
    end
    req = 2'b00;
    step(); check("max_end", 2'b00, 2'b00, 1'b0, 4'd15);

    // Zero length: done one cycle after grant, counter untouched.
    req = 2'b01; len0 = 4'd0;
    step(); check("zero_grant", 2'b01, 2'b00, 1'b1, 4'd15);
    req = 2'b00;
    step(); check("zero_done", 2'b01, 2'b01, 1'b1, 4'd15);
    step(); check("zero_end", 2'b00, 2'b00, 1'b0, 4'd15);

    // Abort at cnt=3, then contention grants requester 1 first.
    do_reset();
    req = 2'b01; len0 = 4'd8; tick = 1'b1;
    step(); check("abort_grant", 2'b01, 2'b00, 1'b1, 4'd0);
    step(); check("abort_clear", 2'b01, 2'b00, 1'b1, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      step(); check($sformatf("abort_cnt%0d", k), 2'b01, 2'b00, 1'b1, 4'(k));
    end
    req = 2'b00;
    step(); check("abort_idle", 2'b00, 2'b00, 1'b0, 4'd3);
    step(); check("abort_hold", 2'b00, 2'b00, 1'b0, 4'd3);
    req = 2'b11; len1 = 4'd2;
    step(); check("abort_rr", 2'b10, 2'b00, 1'b1, 4'd3);

    // Asynchronous reset between edges during COUNT.
    do_reset();
    req = 2'b01; len0 = 4'd8; tick = 1'b1;
    step(); step(); step();
    check("arst_pre", 2'b01, 2'b00, 1'b1, 4'd1);
    #2 rst = 1'b1;
    #1 check("arst_now", 2'b00, 2'b00, 1'b0, 4'd0);
    req = 2'b11; len0 = 4'd1; len1 = 4'd1;
    #2 rst = 1'b0;
    step(); check("arst_rr", 2'b01, 2'b00, 1'b1, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
